sdram_slot_arbiter: RTL and testbench

- Time-slot scheduler that shares the single 16-bit SDRAM between three requesters: Amiga chipset DMA (chip), TG68K CPU (cpu) and host/OSD controller (host).
- Sits between the requesters and the SDRAM command sequencer, running on the fast SDRAM system clock.
- Locks slots to the 7 MHz Amiga bus phase, so chip DMA gets deterministic latency.
- Interleaves auto-refresh and round-robin CPU/host access.

---
 rtl/sdram_slot_arbiter.sv | 94 +++++++++
 tb/tb_sdram_slot_arbiter.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/sdram_slot_arbiter.sv
// sdram_slot_arbiter: 7 MHz phase-locked time-slot scheduler sharing one SDRAM between chip DMA, CPU and host
// Ports: clk/rst (async, active-high); c_7m bus clock (async, synchronised here);
//   chip/cpu/host _req/_we level requests; grant one-hot {host,cpu,chip}, cmd_start/cmd_we/refresh
//   to the command sequencer; *_ack one-cycle completion pulses; slot_phase/locked phase status.
module sdram_slot_arbiter #(
  parameter int SLOT_CYCLES     = 8,
  parameter int ACK_OFFSET      = 6,
  parameter int REFRESH_PERIODS = 55
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                c_7m,
  input  logic                                chip_req,
  input  logic                                chip_we,
  input  logic                                cpu_req,
  input  logic                                cpu_we,
  input  logic                                host_req,
  input  logic                                host_we,
  output logic [2:0]                          grant,
  output logic                                cmd_start,
  output logic                                cmd_we,
  output logic                                refresh,
  output logic                                chip_ack,
  output logic                                cpu_ack,
  output logic                                host_ack,
  output logic [$clog2(2*SLOT_CYCLES)-1:0]    slot_phase,
  output logic                                locked
);
  localparam int PW = $clog2(2*SLOT_CYCLES);
  localparam int RW = $clog2(REFRESH_PERIODS+1);
  localparam logic [PW-1:0] P_LAST  = PW'(2*SLOT_CYCLES-1);
  localparam logic [PW-1:0] P_B     = PW'(SLOT_CYCLES);
  localparam logic [PW-1:0] P_ACK_A = PW'(ACK_OFFSET);
  localparam logic [PW-1:0] P_ACK_B = PW'(SLOT_CYCLES+ACK_OFFSET);
  localparam logic [RW-1:0] R_INIT  = RW'(REFRESH_PERIODS);
  logic [2:0]    sync;
  logic [PW-1:0] nphase;
  logic [RW-1:0] ref_cnt;
  logic [2:0]    own_n, rr;
  logic          c7_rise, lock_n, dec_a, dec_b, dec, ack_cyc;
  logic          pick_cpu, pick_host, ref_n, we_n, last_host, refresh_pending;
  // Any synchronised c_7m rise restarts the period; at the last phase this is the normal
  // wrap, anywhere else it aborts the running slot because no ack cycle is ever reached.
  always_comb begin
    c7_rise   = sync[1] & ~sync[2];
    lock_n    = locked | c7_rise;
    nphase    = (c7_rise || slot_phase == P_LAST) ? '0 : slot_phase + PW'(1);
    dec_a     = lock_n && nphase == '0;
    dec_b     = lock_n && nphase == P_B;
    dec       = dec_a | dec_b;
    ack_cyc   = lock_n && (nphase == P_ACK_A || nphase == P_ACK_B);
    pick_cpu  = cpu_req & (~host_req | last_host);
    pick_host = host_req & ~pick_cpu;
    rr        = {pick_host, pick_cpu, 1'b0};
    ref_n     = dec_b & refresh_pending;
    own_n     = dec_a ? (chip_req ? 3'b001 : rr) : (refresh_pending ? 3'b000 : rr);
    we_n      = (own_n[0] & chip_we) | (own_n[1] & cpu_we) | (own_n[2] & host_we);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync            <= '0;
      slot_phase      <= '0;
      locked          <= 1'b0;
      grant           <= '0;
      cmd_we          <= 1'b0;
      cmd_start       <= 1'b0;
      refresh         <= 1'b0;
      chip_ack        <= 1'b0;
      cpu_ack         <= 1'b0;
      host_ack        <= 1'b0;
      last_host       <= 1'b1;
      refresh_pending <= 1'b0;
      ref_cnt         <= R_INIT;
    end else begin
      sync       <= {sync[1:0], c_7m};
      slot_phase <= nphase;
      locked     <= lock_n;
      grant      <= dec ? own_n : grant;
      cmd_we     <= dec ? we_n : cmd_we;
      cmd_start  <= dec & ((|own_n) | ref_n);
      refresh    <= ref_n;
      chip_ack   <= ack_cyc & grant[0];
      cpu_ack    <= ack_cyc & grant[1];
      host_ack   <= ack_cyc & grant[2];
      last_host  <= (dec && own_n[2:1] != 2'b00) ? own_n[2] : last_host;
      if (dec_a) begin
        ref_cnt         <= (ref_cnt == RW'(1)) ? R_INIT : ref_cnt - RW'(1);
        refresh_pending <= (ref_cnt == RW'(1)) | refresh_pending;
      end else if (ref_n) begin
        refresh_pending <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_sdram_slot_arbiter.sv
// tb_sdram_slot_arbiter: directed self-checking bench for sdram_slot_arbiter
module tb_sdram_slot_arbiter;
  logic       clk = 1'b0, rst = 1'b1, c_7m = 1'b0;
  logic       chip_req = 1'b0, chip_we = 1'b0, cpu_req = 1'b0, cpu_we = 1'b0, host_req = 1'b0, host_we = 1'b0;
  logic [2:0] grant;
  logic       cmd_start, cmd_we, refresh, chip_ack, cpu_ack, host_ack, locked;
  logic [3:0] slot_phase;
  logic       c7_en = 1'b0;
  int         c7_cnt = 0;
  int         n_chk = 0, n_fail = 0;
  sdram_slot_arbiter dut (
    .clk(clk), .rst(rst), .c_7m(c_7m),
    .chip_req(chip_req), .chip_we(chip_we), .cpu_req(cpu_req), .cpu_we(cpu_we),
    .host_req(host_req), .host_we(host_we),
    .grant(grant), .cmd_start(cmd_start), .cmd_we(cmd_we), .refresh(refresh),
    .chip_ack(chip_ack), .cpu_ack(cpu_ack), .host_ack(host_ack),
    .slot_phase(slot_phase), .locked(locked)
  );
  initial forever #5 clk = ~clk;
  // c_7m at clk/16, changed 2 ns after a rising clk edge
  initial forever begin
    @(posedge clk);
    #2;
    if (c7_en) begin
      c7_cnt++;
      if (c7_cnt == 8) begin
        c7_cnt = 0;
        c_7m = ~c_7m;
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
    $fatal(1, "timeout");
  end
  // returns at the negedge where slot_phase=0 of locked period 1
  task automatic relock();
    @(negedge clk);
    c7_en = 1'b0;
    c_7m = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    c7_cnt = 7;
    c7_en = 1'b1;
    repeat (4) @(negedge clk);
  endtask
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_chk++; if (grant !== 3'b000) begin n_fail++; $display("FAIL rst_grant: got %b want 000", grant); end
    n_chk++; if ({cmd_start, cmd_we, refresh, chip_ack, cpu_ack, host_ack} !== 6'b0) begin n_fail++; $display("FAIL rst_flags: got %b want 000000", {cmd_start, cmd_we, refresh, chip_ack, cpu_ack, host_ack}); end
    n_chk++; if (slot_phase !== 4'd0) begin n_fail++; $display("FAIL rst_phase: got %0d want 0", slot_phase); end
    n_chk++; if (locked !== 1'b0) begin n_fail++; $display("FAIL rst_locked: got %b want 0", locked); end
  endtask
  task automatic test_lock();
    cpu_req = 1'b1;
    rst = 1'b0;
    repeat (4) @(negedge clk);
    n_chk++; if ({locked, grant} !== 4'b0000) begin n_fail++; $display("FAIL unlocked_idle: got %b want 0000", {locked, grant}); end
    c7_cnt = 7;
    c7_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_chk++; if ({locked, grant, cpu_ack} !== 5'b0) begin n_fail++; $display("FAIL prelock_%0d: got %b want 00000", i, {locked, grant, cpu_ack}); end
    end
    @(negedge clk);
    n_chk++; if (locked !== 1'b1 || slot_phase !== 4'd0) begin n_fail++; $display("FAIL lock: got locked=%b phase=%0d want 1/0", locked, slot_phase); end
    n_chk++; if (grant !== 3'b010 || cmd_start !== 1'b1) begin n_fail++; $display("FAIL lock_grant: got %b/%b want 010/1", grant, cmd_start); end
    repeat (6) @(negedge clk);
    n_chk++; if (cpu_ack !== 1'b1 || slot_phase !== 4'd6) begin n_fail++; $display("FAIL lock_ack: got ack=%b phase=%0d want 1/6", cpu_ack, slot_phase); end
    cpu_req = 1'b0;
  endtask
  task automatic test_chip_cpu();
    relock();
    repeat (15) @(negedge clk);
    chip_req = 1'b1; chip_we = 1'b0; cpu_req = 1'b1; cpu_we = 1'b1;
    @(negedge clk);
    n_chk++; if ({grant, cmd_start, cmd_we} !== 5'b00110 || slot_phase !== 4'd0) begin n_fail++; $display("FAIL slotA_chip: got grant=%b start=%b we=%b phase=%0d want 001/1/0/0", grant, cmd_start, cmd_we, slot_phase); end
    @(negedge clk);
    n_chk++; if (cmd_start !== 1'b0) begin n_fail++; $display("FAIL start_pulse: got %b want 0", cmd_start); end
    repeat (5) @(negedge clk);
    n_chk++; if ({chip_ack, cpu_ack, grant} !== 5'b10001) begin n_fail++; $display("FAIL chip_ack: got ack=%b%b grant=%b want 10/001", chip_ack, cpu_ack, grant); end
    chip_req = 1'b0;
    @(negedge clk);
    n_chk++; if (chip_ack !== 1'b0 || grant !== 3'b001) begin n_fail++; $display("FAIL chip_hold: got ack=%b grant=%b want 0/001", chip_ack, grant); end
    @(negedge clk);
    n_chk++; if ({grant, cmd_start, cmd_we} !== 5'b01011 || slot_phase !== 4'd8) begin n_fail++; $display("FAIL slotB_cpu: got grant=%b start=%b we=%b phase=%0d want 010/1/1/8", grant, cmd_start, cmd_we, slot_phase); end
    repeat (6) @(negedge clk);
    n_chk++; if (cpu_ack !== 1'b1 || slot_phase !== 4'd14) begin n_fail++; $display("FAIL cpu_ack: got %b phase=%0d want 1/14", cpu_ack, slot_phase); end
    cpu_req = 1'b0;
    repeat (2) @(negedge clk);
    n_chk++; if (grant !== 3'b000 || cmd_start !== 1'b0) begin n_fail++; $display("FAIL idle_after: got %b/%b want 000/0", grant, cmd_start); end
  endtask
  task automatic test_round_robin();
    logic [2:0] exp_g [4];
    exp_g[0] = 3'b010; exp_g[1] = 3'b100; exp_g[2] = 3'b010; exp_g[3] = 3'b100;
    relock();
    cpu_req = 1'b1; cpu_we = 1'b1; host_req = 1'b1; host_we = 1'b0;
    for (int i = 0; i < 4; i++) begin
      repeat (8) @(negedge clk);
      n_chk++; if (grant !== exp_g[i] || cmd_we !== exp_g[i][1]) begin n_fail++; $display("FAIL rr_%0d: got grant=%b we=%b want %b/%b", i, grant, cmd_we, exp_g[i], exp_g[i][1]); end
      if (i < 2) begin
        repeat (6) @(negedge clk);
        n_chk++; if ({host_ack, cpu_ack} !== exp_g[i][2:1]) begin n_fail++; $display("FAIL rr_ack_%0d: got %b want %b", i, {host_ack, cpu_ack}, exp_g[i][2:1]); end
        repeat (2) @(negedge clk);
        i++;
        n_chk++; if (grant !== exp_g[i]) begin n_fail++; $display("FAIL rr_%0d: got %b want %b", i, grant, exp_g[i]); end
        repeat (6) @(negedge clk);
        n_chk++; if ({host_ack, cpu_ack} !== exp_g[i][2:1]) begin n_fail++; $display("FAIL rr_ack_%0d: got %b want %b", i, {host_ack, cpu_ack}, exp_g[i][2:1]); end
        repeat (2) @(negedge clk);
        i++;
        n_chk++; if (grant !== exp_g[i]) begin n_fail++; $display("FAIL rr_%0d: got %b want %b", i, grant, exp_g[i]); end
      end
    end
    cpu_req = 1'b0; host_req = 1'b0; cpu_we = 1'b0;
  endtask
  task automatic test_resync();
    relock();
    cpu_req = 1'b1;
    repeat (8) @(negedge clk);
    n_chk++; if (grant !== 3'b010) begin n_fail++; $display("FAIL rs_grant: got %b want 010", grant); end
    repeat (3) @(negedge clk);
    c7_en = 1'b0; c_7m = 1'b1; c7_cnt = 0; c7_en = 1'b1;
    repeat (2) @(negedge clk);
    n_chk++; if (slot_phase !== 4'd13 || cpu_ack !== 1'b0) begin n_fail++; $display("FAIL rs_pre: got phase=%0d ack=%b want 13/0", slot_phase, cpu_ack); end
    @(negedge clk);
    n_chk++; if (slot_phase !== 4'd0 || locked !== 1'b1 || cmd_start !== 1'b1 || cpu_ack !== 1'b0) begin n_fail++; $display("FAIL rs_restart: got phase=%0d locked=%b start=%b ack=%b want 0/1/1/0", slot_phase, locked, cmd_start, cpu_ack); end
    n_chk++; if (grant !== 3'b010) begin n_fail++; $display("FAIL rs_regrant: got %b want 010", grant); end
    repeat (6) @(negedge clk);
    n_chk++; if (cpu_ack !== 1'b1 || slot_phase !== 4'd6) begin n_fail++; $display("FAIL rs_ack: got %b phase=%0d want 1/6", cpu_ack, slot_phase); end
    cpu_req = 1'b0;
  endtask
  task automatic test_reset_mid();
    relock();
    repeat (15) @(negedge clk);
    chip_req = 1'b1;
    @(negedge clk);
    n_chk++; if (grant !== 3'b001) begin n_fail++; $display("FAIL rm_grant: got %b want 001", grant); end
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    n_chk++; if ({locked, grant, cmd_start, cmd_we, refresh, chip_ack, slot_phase} !== 12'b0) begin n_fail++; $display("FAIL rm_async: got locked=%b grant=%b flags=%b%b%b%b phase=%0d want all 0", locked, grant, cmd_start, cmd_we, refresh, chip_ack, slot_phase); end
    @(negedge clk);
    n_chk++; if (chip_ack !== 1'b0) begin n_fail++; $display("FAIL rm_noack: got %b want 0", chip_ack); end
    relock();
    n_chk++; if (locked !== 1'b1 || grant !== 3'b001) begin n_fail++; $display("FAIL rm_relock: got locked=%b grant=%b want 1/001", locked, grant); end
    repeat (6) @(negedge clk);
    n_chk++; if (chip_ack !== 1'b1) begin n_fail++; $display("FAIL rm_ack: got %b want 1", chip_ack); end
    chip_req = 1'b0;
  endtask
  task automatic test_refresh();
    relock();
    cpu_req = 1'b1; cpu_we = 1'b0;
    repeat (53*16 + 8) @(negedge clk);
    n_chk++; if (refresh !== 1'b0 || grant !== 3'b010 || slot_phase !== 4'd8) begin n_fail++; $display("FAIL ref_p54: got refresh=%b grant=%b phase=%0d want 0/010/8", refresh, grant, slot_phase); end
    repeat (8) @(negedge clk);
    n_chk++; if (refresh !== 1'b0 || grant !== 3'b010) begin n_fail++; $display("FAIL ref_p55A: got refresh=%b grant=%b want 0/010", refresh, grant); end
    repeat (8) @(negedge clk);
    n_chk++; if ({refresh, grant, cmd_start} !== 5'b10001 || slot_phase !== 4'd8) begin n_fail++; $display("FAIL ref_slot: got refresh=%b grant=%b start=%b phase=%0d want 1/000/1/8", refresh, grant, cmd_start, slot_phase); end
    for (int i = 9; i < 16; i++) begin
      @(negedge clk);
      n_chk++; if (cpu_ack !== 1'b0 || refresh !== 1'b0) begin n_fail++; $display("FAIL ref_quiet_%0d: got ack=%b refresh=%b want 0/0", i, cpu_ack, refresh); end
    end
    @(negedge clk);
    n_chk++; if (grant !== 3'b010 || refresh !== 1'b0) begin n_fail++; $display("FAIL ref_next: got grant=%b refresh=%b want 010/0", grant, refresh); end
    repeat (6) @(negedge clk);
    n_chk++; if (cpu_ack !== 1'b1) begin n_fail++; $display("FAIL ref_next_ack: got %b want 1", cpu_ack); end
    cpu_req = 1'b0;
  endtask
  initial begin
    test_reset();
    test_lock();
    test_chip_cpu();
    test_round_robin();
    test_resync();
    test_reset_mid();
    test_refresh();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
